stream_mux_4x1_rr: RTL and testbench

- Four-input to one-output registered stream multiplexer with round-robin arbitration.
- It is the collecting counterpart of the demultiplexer library. A demux routes one source to many sinks; this block merges four valid/ready sources onto one sink.
- It sits in front of shared consumers where several producers contend for one channel.
- Transfers pass through a single output register, so latency is one cycle.

---
 rtl/stream_mux_4x1_rr.sv | 95 +++++++++
 tb/tb_stream_mux_4x1_rr.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_4x1_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_4x1_rr
//
// Purpose:
//   Merges four valid/ready source streams onto one sink through a single
//   output register. Round-robin arbitration picks the source: the search
//   starts at a rotating priority pointer, and that pointer moves to one past
//   the last granted channel. Latency is one cycle. Throughput is one word
//   per cycle while the sink keeps out_ready high.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_data    packed source data, channel i at [i*DATA_W +: DATA_W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit high (the granted channel)
//   out_data   registered output word
//   out_valid  registered output valid
//   out_ready  sink ready
//   out_sel    channel index of the word currently held in out_data
//
// Notes:
//   in_ready is a combinational function of in_valid. Sources must therefore
//   never make in_valid depend on in_ready, or a combinational loop results.
// -----------------------------------------------------------------------------
module stream_mux_4x1_rr #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DATA_W-1:0]   in_data,
    input  logic [3:0]            in_valid,
    output logic [3:0]            in_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_sel
);

    logic [1:0] ptr;
    logic [1:0] grant;
    logic       grant_found;
    logic       load_en;
    logic       transfer;

    // The output register may take a new word when it is empty, or when it
    // drains on this same edge.
    assign load_en = !out_valid || out_ready;

    // Rotating priority search: ptr, ptr+1, ptr+2, ptr+3 (mod 4). The 2-bit
    // add wraps for us.
    always_comb begin
        logic [1:0] idx;
        grant       = ptr;
        grant_found = 1'b0;
        idx         = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!grant_found && in_valid[idx]) begin
                grant       = idx;
                grant_found = 1'b1;
            end
        end
    end

    // Hold off all sources during reset. A request presented then is
    // therefore never consumed.
    always_comb begin
        in_ready = 4'b0000;
        if (!rst && load_en && grant_found) begin
            in_ready = 4'b0001 << grant;
        end
    end

    // in_ready is only ever raised on a channel whose valid is high.
    assign transfer = |in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            ptr       <= 2'd0;
        end else if (transfer) begin
            out_data  <= in_data[grant*DATA_W +: DATA_W];
            out_sel   <= grant;
            out_valid <= 1'b1;
            ptr       <= grant + 2'd1;
        end else if (out_valid && out_ready) begin
            // Drain without refill: data and sel keep their last values.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_4x1_rr.sv
module tb_stream_mux_4x1_rr;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sel;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard entries are {sel, data}.
    logic [9:0] sb[$];

    stream_mux_4x1_rr #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle. Drive the inputs at posedge+1 and check in_ready. If
    // the held word drains this cycle, pop and compare it. If a transfer is
    // expected, push the expected word. The task returns at the next
    // posedge+1.
    task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic r,
                         input logic [3:0] er, input string name);
        logic [1:0] g;
        logic [9:0] e;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        vectors++;
        if (in_ready !== er) begin
            miscompares++;
            $display("FAIL %s in_ready got %b want %b", name, in_ready, er);
        end
        if (out_valid === 1'b1 && r) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL %s unexpected output sel=%0d data=%h", name, out_sel, out_data);
            end else begin
                e = sb.pop_front();
                if ({out_sel, out_data} !== e) begin
                    miscompares++;
                    $display("FAIL %s output got sel=%0d data=%h want sel=%0d data=%h",
                             name, out_sel, out_data, e[9:8], e[7:0]);
                end
            end
        end
        if (er != 4'b0000) begin
            g = 2'd0;
            for (int i = 0; i < 4; i++) if (er[i]) g = 2'(i);
            sb.push_back({g, d[g*8 +: 8]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 4'b0000;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 4'b1111;
        in_data = 32'h44332211;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if ({out_valid, out_sel, out_data} !== 11'h000 || in_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset got v=%b sel=%0d data=%h rdy=%b want 0 0 00 0000",
                     out_valid, out_sel, out_data, in_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0000, 32'h0, 1'b1, 4'b0000, "idle_ready");
            vectors++;
            if ({out_valid, out_sel, out_data} !== 11'h000) begin
                miscompares++;
                $display("FAIL idle_out got v=%b sel=%0d data=%h want 0 0 00",
                         out_valid, out_sel, out_data);
            end
        end
    endtask

    task automatic test_single();
        cycle(4'b0100, 32'h00A50000, 1'b1, 4'b0100, "single_load");
        vectors++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd2, 8'hA5}) begin
            miscompares++;
            $display("FAIL single_out got v=%b sel=%0d data=%h want 1 2 a5",
                     out_valid, out_sel, out_data);
        end
        cycle(4'b0000, 32'h0, 1'b1, 4'b0000, "single_drain");
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_empty out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 5; i++)
            cycle(4'b1111, 32'h13121110, 1'b1, exp_rdy[i], "rr");
        cycle(4'b0000, 32'h0, 1'b1, 4'b0000, "rr_drain");
    endtask

    task automatic test_wrap();
        // After the round-robin run ptr=1. Grant channel 3 alone, so ptr=0.
        cycle(4'b1000, 32'h33000000, 1'b1, 4'b1000, "wrap_ch3");
        cycle(4'b0101, 32'h00420040, 1'b1, 4'b0001, "wrap_ch0_wins");
        cycle(4'b0100, 32'h00420000, 1'b1, 4'b0100, "wrap_ch2_next");
        cycle(4'b0000, 32'h0, 1'b1, 4'b0000, "wrap_drain");
    endtask

    task automatic test_backpressure();
        // ptr=3 here. Channel 1 alone wins, so ptr=2 afterwards.
        cycle(4'b0010, 32'h00005C00, 1'b1, 4'b0010, "bp_load");
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1001, 32'hC30000C0, 1'b0, 4'b0000, "bp_hold_ready");
            vectors++;
            if ({out_valid, out_sel, out_data} !== {1'b1, 2'd1, 8'h5C}) begin
                miscompares++;
                $display("FAIL bp_hold got v=%b sel=%0d data=%h want 1 1 5c",
                         out_valid, out_sel, out_data);
            end
        end
        cycle(4'b1001, 32'hC30000C0, 1'b1, 4'b1000, "bp_release");
        vectors++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd3, 8'hC3}) begin
            miscompares++;
            $display("FAIL bp_refill got v=%b sel=%0d data=%h want 1 3 c3",
                     out_valid, out_sel, out_data);
        end
        cycle(4'b0000, 32'h0, 1'b1, 4'b0000, "bp_drain");
    endtask

    task automatic test_reset_mid();
        // ptr=0 here. Load 0x77 from channel 0, so ptr=1.
        cycle(4'b0001, 32'h00000077, 1'b1, 4'b0001, "mid_load");
        cycle(4'b0000, 32'h0, 1'b0, 4'b0000, "mid_hold");
        rst = 1'b1;
        in_valid = 4'b0010;
        in_data = 32'h00002100;
        out_ready = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_rst_ready got %b want 0000", in_ready);
        end
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({out_valid, out_sel, out_data} !== 11'h000) begin
            miscompares++;
            $display("FAIL mid_rst_out got v=%b sel=%0d data=%h want 0 0 00",
                     out_valid, out_sel, out_data);
        end
        // Channels 0 and 3 both valid. A reset ptr picks 0; a stale ptr=1
        // would pick 3.
        cycle(4'b1001, 32'h23000020, 1'b1, 4'b0001, "mid_after_rst");
        cycle(4'b0000, 32'h0, 1'b1, 4'b0000, "mid_drain");
    endtask

    task automatic test_back_to_back();
        logic [1:0]  mptr;
        logic        mov;
        logic [3:0]  v;
        logic [31:0] d;
        logic        r;
        logic [3:0]  er;
        logic [1:0]  idx;
        do_reset();
        mptr = 2'd0;
        mov  = 1'b0;
        for (int n = 0; n < 200; n++) begin
            v  = 4'($urandom_range(0, 15));
            d  = $urandom;
            r  = ($urandom_range(0, 3) != 0);
            er = 4'b0000;
            if (!mov || r) begin
                for (int off = 3; off >= 0; off--) begin
                    idx = mptr + 2'(off);
                    if (v[idx]) er = 4'b0001 << idx;
                end
            end
            cycle(v, d, r, er, "b2b");
            if (er != 4'b0000) begin
                for (int i = 0; i < 4; i++) if (er[i]) mptr = 2'(i) + 2'd1;
                mov = 1'b1;
            end else if (r) begin
                mov = 1'b0;
            end
            vectors++;
            if (out_valid !== mov) begin
                miscompares++;
                $display("FAIL b2b_valid got %b want %b", out_valid, mov);
            end
        end
        cycle(4'b0000, 32'h0, 1'b1, 4'b0000, "b2b_drain");
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_leftover got %0d words want 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 4'b0000;
        in_data = 32'h0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL final_scoreboard got %0d words want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
